monster_formation_ctrl: RTL and testbench

//  Sequencer for the monster formation rectangle. Produces topLeftX/topLeftY for the monster square object.

---
 rtl/monster_formation_ctrl.sv | 176 +++++++++++++++++
 tb/tb_monster_formation_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/monster_formation_ctrl.sv
// Formation sequencer for the monster block: marches left/right one step every
// few frames, drops a row at each screen edge, and flags landing and wave clear.
module monster_formation_ctrl #(
    parameter int START_X      = 32,
    parameter int START_Y      = 48,
    parameter int STEP_X       = 8,
    parameter int STEP_Y       = 16,
    parameter int FORM_W       = 512,
    parameter int FORM_H       = 256,
    parameter int LEFT_LIMIT   = 0,
    parameter int RIGHT_LIMIT  = 640,
    parameter int BOTTOM_LIMIT = 464,
    parameter int MIN_PERIOD   = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startGame,
    input  logic               resetGame,
    input  logic               pause,
    input  logic [5:0]         aliveCount,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               dirRight,
    output logic               stepPulse,
    output logic               landed,
    output logic               waveCleared
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MARCH   = 2'd1;
    localparam logic [1:0] ST_DESCEND = 2'd2;
    localparam logic [1:0] ST_LANDED  = 2'd3;

    localparam logic signed [10:0] START_X_11 = 11'(START_X);
    localparam logic signed [10:0] START_Y_11 = 11'(START_Y);
    localparam logic signed [10:0] STEP_X_11  = 11'(STEP_X);
    localparam logic signed [10:0] STEP_Y_11  = 11'(STEP_Y);

    // Edge and landing compares are done one bit wider so X+FORM_W cannot wrap.
    localparam logic signed [11:0] STEP_X_12       = 12'(STEP_X);
    localparam logic signed [11:0] FORM_W_12       = 12'(FORM_W);
    localparam logic signed [11:0] FORM_H_12       = 12'(FORM_H);
    localparam logic signed [11:0] LEFT_LIMIT_12   = 12'(LEFT_LIMIT);
    localparam logic signed [11:0] RIGHT_LIMIT_12  = 12'(RIGHT_LIMIT);
    localparam logic signed [11:0] BOTTOM_LIMIT_12 = 12'(BOTTOM_LIMIT);

    localparam logic [4:0] MIN_PERIOD_5 = 5'(MIN_PERIOD);

    logic [1:0]         state_reg, state_next;
    logic [4:0]         frame_cnt_reg, frame_cnt_next;
    logic signed [10:0] x_reg, x_next;
    logic signed [10:0] y_reg, y_next;
    logic               dir_reg, dir_next;
    logic               step_reg, step_next;
    logic               landed_reg, landed_next;
    logic               cleared_reg, cleared_next;

    logic [4:0]         period;
    logic [4:0]         period_m1;
    logic signed [11:0] x_ext;
    logic signed [10:0] y_desc;
    logic signed [11:0] y_desc_ext;
    logic               right_hit;
    logic               left_hit;
    logic               land_hit;
    logic               running;
    logic               alive_zero;
    logic               step_event;
    logic               step_take;

    // Fewer survivors -> shorter period -> faster march.
    assign period     = MIN_PERIOD_5 + {1'b0, aliveCount[5:2]};
    assign period_m1  = period - 5'd1;

    assign x_ext      = {x_reg[10], x_reg};
    assign y_desc     = y_reg + STEP_Y_11;
    assign y_desc_ext = {y_desc[10], y_desc};

    assign right_hit  = (x_ext + FORM_W_12 + STEP_X_12) > RIGHT_LIMIT_12;
    assign left_hit   = (x_ext - STEP_X_12) < LEFT_LIMIT_12;
    assign land_hit   = (y_desc_ext + FORM_H_12) >= BOTTOM_LIMIT_12;

    assign running    = (state_reg == ST_MARCH) || (state_reg == ST_DESCEND);
    assign alive_zero = (aliveCount == 6'd0);
    assign step_event = startOfFrame && !pause && !alive_zero && running;
    assign step_take  = step_event && (frame_cnt_reg >= period_m1);

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        dir_next       = dir_reg;
        step_next      = 1'b0;

        if (resetGame) begin
            state_next     = ST_IDLE;
            frame_cnt_next = 5'd0;
            x_next         = START_X_11;
            y_next         = START_Y_11;
            dir_next       = 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (startGame) begin
                        state_next     = ST_MARCH;
                        frame_cnt_next = 5'd0;
                    end
                end
                ST_MARCH: begin
                    if (step_take) begin
                        frame_cnt_next = 5'd0;
                        // Hitting an edge spends this step on the turn; X does not move.
                        if ((dir_reg && right_hit) || (!dir_reg && left_hit)) begin
                            state_next = ST_DESCEND;
                        end else begin
                            x_next    = dir_reg ? (x_reg + STEP_X_11) : (x_reg - STEP_X_11);
                            step_next = 1'b1;
                        end
                    end else if (step_event) begin
                        frame_cnt_next = frame_cnt_reg + 5'd1;
                    end
                end
                ST_DESCEND: begin
                    if (step_take) begin
                        frame_cnt_next = 5'd0;
                        y_next         = y_desc;
                        dir_next       = !dir_reg;
                        step_next      = 1'b1;
                        state_next     = land_hit ? ST_LANDED : ST_MARCH;
                    end else if (step_event) begin
                        frame_cnt_next = frame_cnt_reg + 5'd1;
                    end
                end
                default: begin
                    state_next = ST_LANDED;
                end
            endcase
        end

        landed_next  = (state_next == ST_LANDED);
        cleared_next = alive_zero &&
                       ((state_next == ST_MARCH) || (state_next == ST_DESCEND));
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= 5'd0;
            x_reg         <= START_X_11;
            y_reg         <= START_Y_11;
            dir_reg       <= 1'b1;
            step_reg      <= 1'b0;
            landed_reg    <= 1'b0;
            cleared_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            dir_reg       <= dir_next;
            step_reg      <= step_next;
            landed_reg    <= landed_next;
            cleared_reg   <= cleared_next;
        end
    end

    assign topLeftX    = x_reg;
    assign topLeftY    = y_reg;
    assign dirRight    = dir_reg;
    assign stepPulse   = step_reg;
    assign landed      = landed_reg;
    assign waveCleared = cleared_reg;

endmodule

// File: tb/tb_monster_formation_ctrl.sv
// Directed bench for the formation sequencer: reset, step timing, edge turn,
// speed-up, pause, wave clear, landing and resetGame priority.
module tb_monster_formation_ctrl;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               startGame;
    logic               resetGame;
    logic               pause;
    logic [5:0]         aliveCount;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               dirRight;
    logic               stepPulse;
    logic               landed;
    logic               waveCleared;

    int n_checks = 0;
    int n_fail   = 0;

    monster_formation_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startGame    (startGame),
        .resetGame    (resetGame),
        .pause        (pause),
        .aliveCount   (aliveCount),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .dirRight     (dirRight),
        .stepPulse    (stepPulse),
        .landed       (landed),
        .waveCleared  (waveCleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // All tasks start and end on a falling edge; outputs are sampled there.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            @(negedge clk);
            startOfFrame = 1'b0;
        end
    endtask

    task automatic pulse_start();
        startGame = 1'b1;
        @(negedge clk);
        startGame = 1'b0;
    endtask

    int prev_y;
    int n_frames;

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        startGame    = 1'b0;
        resetGame    = 1'b0;
        pause        = 1'b0;
        aliveCount   = 6'd40;

        // Reset
        repeat (2) @(negedge clk);
        check_eq("reset_x", topLeftX, 32);
        check_eq("reset_y", topLeftY, 48);
        check_eq("reset_dir", dirRight, 1);
        check_eq("reset_landed", landed, 0);
        check_eq("reset_step", stepPulse, 0);
        check_eq("reset_cleared", waveCleared, 0);
        resetN = 1'b1;
        @(negedge clk);
        frames(3);
        check_eq("idle_ignores_frames_x", topLeftX, 32);

        // Timing: period 12 with 40 alive
        pulse_start();
        frames(11);
        check_eq("before_12th_x", topLeftX, 32);
        check_eq("before_12th_step", stepPulse, 0);
        frames(1);
        check_eq("after_12th_x", topLeftX, 40);
        check_eq("after_12th_step", stepPulse, 1);
        @(negedge clk);
        check_eq("step_pulse_width", stepPulse, 0);

        // Right edge: 11 more steps reach 128, then one turn step and one descent
        frames(11 * 12);
        check_eq("edge_x128", topLeftX, 128);
        frames(12);
        check_eq("turn_x_held", topLeftX, 128);
        check_eq("turn_y_held", topLeftY, 48);
        check_eq("turn_no_pulse", stepPulse, 0);
        frames(12);
        check_eq("descend_y", topLeftY, 64);
        check_eq("descend_dir", dirRight, 0);
        check_eq("descend_pulse", stepPulse, 1);
        check_eq("descend_x", topLeftX, 128);

        // Speed-up mid-count: frameCnt=5, then period drops to 2
        frames(5);
        check_eq("mid_count_x", topLeftX, 128);
        aliveCount = 6'd3;
        frames(1);
        check_eq("speedup_first_x", topLeftX, 120);
        frames(1);
        check_eq("speedup_hold_x", topLeftX, 120);
        frames(1);
        check_eq("speedup_second_x", topLeftX, 112);

        // Pause for 20 frames; frameCnt must stay 0 so stepping needs 2 frames after
        pause = 1'b1;
        frames(20);
        check_eq("pause_x", topLeftX, 112);
        check_eq("pause_y", topLeftY, 64);
        pause = 1'b0;
        frames(1);
        check_eq("unpause_first_x", topLeftX, 112);
        frames(1);
        check_eq("unpause_second_x", topLeftX, 104);

        // Wave clear
        aliveCount = 6'd0;
        @(negedge clk);
        check_eq("cleared_set", waveCleared, 1);
        frames(10);
        check_eq("cleared_no_motion_x", topLeftX, 104);
        aliveCount = 6'd5;
        @(negedge clk);
        check_eq("cleared_drop", waveCleared, 0);
        frames(2);
        check_eq("resume_hold_x", topLeftX, 104);
        frames(1);
        check_eq("resume_step_x", topLeftX, 96);

        // Landing: march until landed, 10th descent lands at Y=208 on the left edge
        aliveCount = 6'd3;
        prev_y   = topLeftY;
        n_frames = 0;
        while (!landed && n_frames < 2000) begin
            prev_y = topLeftY;
            frames(1);
            n_frames++;
        end
        check_eq("land_reached", landed, 1);
        check_eq("land_y", topLeftY, 208);
        check_eq("land_prev_y", prev_y, 192);
        check_eq("land_x", topLeftX, 0);
        check_eq("land_dir", dirRight, 1);
        frames(10);
        check_eq("landed_frozen_x", topLeftX, 0);
        check_eq("landed_frozen_y", topLeftY, 208);
        check_eq("landed_hold", landed, 1);

        // resetGame returns to IDLE
        resetGame = 1'b1;
        @(negedge clk);
        resetGame = 1'b0;
        check_eq("rg_x", topLeftX, 32);
        check_eq("rg_y", topLeftY, 48);
        check_eq("rg_landed", landed, 0);
        check_eq("rg_dir", dirRight, 1);

        // resetGame beats startGame, and beats a due step
        pulse_start();
        frames(2);
        check_eq("restart_x", topLeftX, 40);
        frames(1);
        resetGame    = 1'b1;
        startGame    = 1'b1;
        startOfFrame = 1'b1;
        @(negedge clk);
        resetGame    = 1'b0;
        startGame    = 1'b0;
        startOfFrame = 1'b0;
        check_eq("prio_x", topLeftX, 32);
        check_eq("prio_y", topLeftY, 48);
        check_eq("prio_no_pulse", stepPulse, 0);
        frames(4);
        check_eq("prio_idle_x", topLeftX, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
